// File: rtl/shared_adder_arbiter.sv
// -----------------------------------------------------------------------------
// shared_adder_arbiter
//
// Lets NREQ requesters share one registered adder. The arbiter is round-robin.
// A requester offers an operand pair with a valid/ready handshake. At most one
// request is granted per cycle. The granted operands go to the adder, and the
// registered sum enters a 2-entry result FIFO tagged with the requester index.
// Results leave the FIFO in issue order under downstream backpressure.
//
// Ports
//   i_clk    : clock; all state changes on the rising edge
//   i_reset  : synchronous, active-high reset
//   i_valid  : [NREQ]        per-requester request valid
//   i_a      : [NREQ*AWIDTH] packed operand a, requester k at [k*AWIDTH +: AWIDTH]
//   i_b      : [NREQ*BWIDTH] packed operand b, requester k at [k*BWIDTH +: BWIDTH]
//   o_ready  : [NREQ]        one-hot grant (combinational)
//   o_valid  : result available at the FIFO head
//   o_sum    : [OUTWID]      head result a+b, zero when o_valid is low
//   o_id     : [IDW]         requester index of the head result, zero when idle
//   i_ready  : downstream accepts the head when o_valid && i_ready
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// unsigned_adder
//
// One-cycle registered unsigned adder. The output is one bit wider than the
// wider operand, so the sum cannot overflow.
//
// Ports
//   clk  : clock
//   srst : synchronous active-high reset, clears the sum register
//   a    : [AWIDTH] operand a
//   b    : [BWIDTH] operand b
//   sum  : [OUTWID] registered a+b
// -----------------------------------------------------------------------------
module unsigned_adder #(
    parameter int AWIDTH = 16,
    parameter int BWIDTH = 16,
    parameter int OUTWID = ((AWIDTH > BWIDTH) ? AWIDTH : BWIDTH) + 1
) (
    input  logic              clk,
    input  logic              srst,
    input  logic [AWIDTH-1:0] a,
    input  logic [BWIDTH-1:0] b,
    output logic [OUTWID-1:0] sum
);

    logic [OUTWID-1:0] sum_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            sum_reg <= '0;
        end else begin
            sum_reg <= OUTWID'(a) + OUTWID'(b);
        end
    end

    assign sum = sum_reg;

endmodule

module shared_adder_arbiter #(
    parameter int AWIDTH = 16,
    parameter int BWIDTH = 16,
    parameter int NREQ   = 4,
    parameter int OUTWID = ((AWIDTH > BWIDTH) ? AWIDTH : BWIDTH) + 1,
    parameter int IDW    = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [NREQ-1:0]        i_valid,
    input  logic [NREQ*AWIDTH-1:0] i_a,
    input  logic [NREQ*BWIDTH-1:0] i_b,
    output logic [NREQ-1:0]        o_ready,
    output logic                   o_valid,
    output logic [OUTWID-1:0]      o_sum,
    output logic [IDW-1:0]         o_id,
    input  logic                   i_ready
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [IDW-1:0]    rr_ptr_reg;
    logic              p1_valid_reg;
    logic [IDW-1:0]    p1_id_reg;

    logic [OUTWID-1:0] fifo_sum_reg [0:1];
    logic [IDW-1:0]    fifo_id_reg  [0:1];
    logic              wr_ptr_reg;
    logic              rd_ptr_reg;
    logic [1:0]        cnt_reg;

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    logic [AWIDTH-1:0] a_slot [NREQ];
    logic [BWIDTH-1:0] b_slot [NREQ];
    logic [IDW:0]      cand_idx [NREQ];   // requester reached at offset gi from rr_ptr
    logic [NREQ-1:0]   cand_hit;          // that requester is valid

    logic              pop;
    logic              push;
    logic [2:0]        occ_after;
    logic              issue_ok;
    logic              grant_found;
    logic [IDW-1:0]    grant_idx;
    logic              issue;
    logic [AWIDTH-1:0] add_a;
    logic [BWIDTH-1:0] add_b;
    logic [OUTWID-1:0] add_sum;
    logic [IDW-1:0]    rr_ptr_next;
    logic [1:0]        cnt_next;
    logic              head_valid;

    // -------------------------------------------------------------------------
    // Operand unpacking and rotated candidate list
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slot
            assign a_slot[gi] = i_a[gi*AWIDTH +: AWIDTH];
            assign b_slot[gi] = i_b[gi*BWIDTH +: BWIDTH];

            // Cyclic index rr_ptr+gi, wrapped into 0..NREQ-1. Both terms are
            // below NREQ, so one conditional subtract is enough.
            logic [IDW:0] raw_idx;
            assign raw_idx      = {1'b0, rr_ptr_reg} + (IDW+1)'(gi);
            assign cand_idx[gi] = (raw_idx >= (IDW+1)'(NREQ)) ?
                                  (raw_idx - (IDW+1)'(NREQ)) : raw_idx;
            assign cand_hit[gi] = i_valid[cand_idx[gi][IDW-1:0]];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Output FIFO head and pop
    // -------------------------------------------------------------------------
    // The FIFO is held invisible while reset is asserted. This keeps the outputs
    // quiet in the reset cycle and keeps a reset-cycle pop away from the FIFO.
    assign head_valid = (cnt_reg != 2'd0) && !i_reset;
    assign pop        = head_valid && i_ready;
    assign push       = p1_valid_reg;

    assign o_valid = head_valid;
    assign o_sum   = head_valid ? fifo_sum_reg[rd_ptr_reg] : '0;
    assign o_id    = head_valid ? fifo_id_reg[rd_ptr_reg]  : '0;

    // -------------------------------------------------------------------------
    // Issue permission and round-robin grant
    // -------------------------------------------------------------------------
    // Issue only if the FIFO still has a free slot for this result after the
    // in-flight result and this cycle's pop are counted. cnt >= 1 whenever pop
    // is set, so the subtraction cannot underflow.
    assign occ_after = {1'b0, cnt_reg} + {2'b00, p1_valid_reg} - {2'b00, pop};
    assign issue_ok  = (occ_after < 3'd2);

    // Scan offsets from highest to lowest. The last hit written wins, so the
    // valid requester nearest rr_ptr is the one selected.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            if (cand_hit[off]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx[off][IDW-1:0];
            end
        end
    end

    assign issue = issue_ok && grant_found && !i_reset;

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ready
            assign o_ready[gi] = issue && (grant_idx == IDW'(gi));
        end
    endgenerate

    assign rr_ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

    // -------------------------------------------------------------------------
    // Shared adder: operands forced to zero when nothing issues
    // -------------------------------------------------------------------------
    assign add_a = issue ? a_slot[grant_idx] : '0;
    assign add_b = issue ? b_slot[grant_idx] : '0;

    unsigned_adder #(
        .AWIDTH (AWIDTH),
        .BWIDTH (BWIDTH),
        .OUTWID (OUTWID)
    ) u_adder (
        .clk  (i_clk),
        .srst (i_reset),
        .a    (add_a),
        .b    (add_b),
        .sum  (add_sum)
    );

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    assign cnt_next = cnt_reg + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rr_ptr_reg   <= '0;
            p1_valid_reg <= 1'b0;
            p1_id_reg    <= '0;
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            cnt_reg      <= 2'd0;
        end else begin
            p1_valid_reg <= issue;
            if (issue) begin
                rr_ptr_reg <= rr_ptr_next;
                p1_id_reg  <= grant_idx;
            end
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            cnt_reg <= cnt_next;
        end
    end

    // FIFO storage has no reset. Stale entries are never visible, because the
    // head is gated by the occupancy count.
    always_ff @(posedge i_clk) begin
        if (push && !i_reset) begin
            fifo_sum_reg[wr_ptr_reg] <= add_sum;
            fifo_id_reg[wr_ptr_reg]  <= p1_id_reg;
        end
    end

`ifndef SYNTHESIS
    // Issue gating should make a push into a full FIFO impossible.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            assert (!(push && !pop && (cnt_reg == 2'd2)));
            assert (cnt_reg <= 2'd2);
        end
    end
`endif

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shared_adder_arbiter
//
// Directed testbench for shared_adder_arbiter with AWIDTH=BWIDTH=16 and NREQ=4.
// Each test is a sequence of per-cycle vectors. A vector gives the inputs and
// the hand-computed o_ready, o_valid, o_id and o_sum for that cycle.
// -----------------------------------------------------------------------------
module tb_shared_adder_arbiter;

    localparam int AWIDTH = 16;
    localparam int BWIDTH = 16;
    localparam int NREQ   = 4;
    localparam int OUTWID = 17;
    localparam int IDW    = 2;

    logic                   i_clk;
    logic                   i_reset;
    logic [NREQ-1:0]        i_valid;
    logic [NREQ*AWIDTH-1:0] i_a;
    logic [NREQ*BWIDTH-1:0] i_b;
    logic [NREQ-1:0]        o_ready;
    logic                   o_valid;
    logic [OUTWID-1:0]      o_sum;
    logic [IDW-1:0]         o_id;
    logic                   i_ready;

    int checks_cnt;
    int fail_cnt;

    shared_adder_arbiter #(
        .AWIDTH (AWIDTH),
        .BWIDTH (BWIDTH),
        .NREQ   (NREQ)
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_sum   (o_sum),
        .o_id    (o_id),
        .i_ready (i_ready)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Stops the run if it is still going long after every vector should be done.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_ops(input int k, input logic [15:0] a, input logic [15:0] b);
        i_a[k*AWIDTH +: AWIDTH] = a;
        i_b[k*BWIDTH +: BWIDTH] = b;
    endtask

    // Runs one clock cycle. The inputs are driven 1 time unit after the rising
    // edge and the outputs are checked 1 time unit later.
    task automatic cyc(input string tag, input logic rst, input logic [3:0] v,
                       input logic rdy, input logic [3:0] er, input logic ev,
                       input logic [1:0] eid, input logic [16:0] esum);
        i_reset = rst;
        i_valid = v;
        i_ready = rdy;
        #1;
        check({tag, ".ready"}, 32'(o_ready), 32'(er));
        check({tag, ".valid"}, 32'(o_valid), 32'(ev));
        check({tag, ".id"},    32'(o_id),    32'(eid));
        check({tag, ".sum"},   32'(o_sum),   32'(esum));
        if (o_valid && i_ready)
            $display("[%0t] %s result id=%0d sum=%0h", $time, tag, o_id, o_sum);
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        i_reset    = 1'b1;
        i_valid    = '0;
        i_ready    = 1'b1;
        i_a        = '0;
        i_b        = '0;
        @(posedge i_clk);
        #1;

        // Reset state. A request is presented during reset but must not be granted.
        cyc("rst0", 1, 4'b0000, 1, 4'b0000, 0, 0, 0);
        cyc("rst1", 1, 4'b1111, 1, 4'b0000, 0, 0, 0);

        // Single request from requester 2: 10+5 appears at t+2 for one cycle.
        set_ops(2, 16'd10, 16'd5);
        cyc("single", 0, 4'b0100, 1, 4'b0100, 0, 0, 0);
        cyc("single", 0, 4'b0000, 1, 4'b0000, 0, 0, 0);
        cyc("single", 0, 4'b0000, 1, 4'b0000, 1, 2, 17'd15);
        cyc("single", 0, 4'b0000, 1, 4'b0000, 0, 0, 0);

        // Max operands on requester 0. rr_ptr is 3 here, so the scan wraps to 0.
        set_ops(0, 16'hFFFF, 16'hFFFF);
        cyc("max", 0, 4'b0001, 1, 4'b0001, 0, 0, 0);
        cyc("max", 0, 4'b0000, 1, 4'b0000, 0, 0, 0);
        cyc("max", 0, 4'b0000, 1, 4'b0000, 1, 0, 17'h1FFFE);
        cyc("max", 0, 4'b0000, 1, 4'b0000, 0, 0, 0);

        // All four requesters valid: grants rotate 0,1,2,3 and sums are 100+k.
        cyc("rst", 1, 4'b0000, 1, 4'b0000, 0, 0, 0);
        for (int k = 0; k < NREQ; k++) set_ops(k, 16'(k), 16'd100);
        for (int c = 0; c < 8; c++)
            cyc("rr", 0, 4'b1111, 1, 4'(1 << (c % 4)), (c >= 2),
                (c >= 2) ? 2'((c + 2) % 4) : 2'd0,
                (c >= 2) ? 17'(100 + (c + 2) % 4) : 17'd0);
        cyc("rr_drain", 0, 4'b0000, 1, 4'b0000, 1, 2, 17'd102);
        cyc("rr_drain", 0, 4'b0000, 1, 4'b0000, 1, 3, 17'd103);
        cyc("rr_drain", 0, 4'b0000, 1, 4'b0000, 0, 0, 0);

        // Requesters 1 and 3 only: grants alternate 1,3,1,3.
        cyc("rst", 1, 4'b0000, 1, 4'b0000, 0, 0, 0);
        cyc("alt", 0, 4'b1010, 1, 4'b0010, 0, 0, 0);
        cyc("alt", 0, 4'b1010, 1, 4'b1000, 0, 0, 0);
        cyc("alt", 0, 4'b1010, 1, 4'b0010, 1, 1, 17'd101);
        cyc("alt", 0, 4'b1010, 1, 4'b1000, 1, 3, 17'd103);
        cyc("alt", 0, 4'b0000, 1, 4'b0000, 1, 1, 17'd101);
        cyc("alt", 0, 4'b0000, 1, 4'b0000, 1, 3, 17'd103);
        cyc("alt", 0, 4'b0000, 1, 4'b0000, 0, 0, 0);

        // Backpressure: i_ready low for 5 cycles with two results buffered.
        // The head stays at id0, no grants occur, and order survives the restart.
        cyc("rst", 1, 4'b0000, 1, 4'b0000, 0, 0, 0);
        cyc("bp", 0, 4'b1111, 1, 4'b0001, 0, 0, 0);
        cyc("bp", 0, 4'b1111, 1, 4'b0010, 0, 0, 0);
        for (int c = 0; c < 5; c++)
            cyc("bp_stall", 0, 4'b1111, 0, 4'b0000, 1, 0, 17'd100);
        cyc("bp_restart", 0, 4'b1111, 1, 4'b0100, 1, 0, 17'd100);
        cyc("bp", 0, 4'b1111, 1, 4'b1000, 1, 1, 17'd101);
        cyc("bp", 0, 4'b0000, 1, 4'b0000, 1, 2, 17'd102);
        cyc("bp", 0, 4'b0000, 1, 4'b0000, 1, 3, 17'd103);
        cyc("bp", 0, 4'b0000, 1, 4'b0000, 0, 0, 0);

        // Reset with two results buffered. Buffered data must vanish and
        // rr_ptr must return to 0, so requester 1 wins over 2.
        cyc("mid", 0, 4'b1111, 1, 4'b0001, 0, 0, 0);
        cyc("mid", 0, 4'b1111, 1, 4'b0010, 0, 0, 0);
        cyc("mid", 0, 4'b1111, 0, 4'b0000, 1, 0, 17'd100);
        cyc("mid_rst", 1, 4'b1111, 0, 4'b0000, 0, 0, 0);
        cyc("mid_post", 0, 4'b0110, 1, 4'b0010, 0, 0, 0);
        cyc("mid_post", 0, 4'b0000, 1, 4'b0000, 0, 0, 0);
        cyc("mid_post", 0, 4'b0000, 1, 4'b0000, 1, 1, 17'd101);
        cyc("mid_post", 0, 4'b0000, 1, 4'b0000, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
